// File: rtl/mem_lsu.sv
// mem_lsu: RV64 memory-access stage, req/ack data bus with stall; MEM_MISALIGN_CHK_EN enables the misaligned-access check
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ex_rd_data,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_rd_ena,
  input  logic [3:0]  ex_mem_op,
  input  logic [63:0] ex_mem_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] mem_rd_data,
  output logic [4:0]  mem_rd_addr,
  output logic        mem_rd_ena,
  output logic        stall_req_mem,
  output logic        mem_misalign
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, next;
  logic is_st, is_ld, acc, mis, mis_q, we_q, ld_q, uns_q, rd_ena_q, ok;
  logic [1:0] sz, sz_q;
  logic [2:0] lane, lane_q;
  logic [4:0] rd_addr_q;
  logic [7:0] strb, strb_q;
  logic [63:0] wdata, addr_q, wdata_q, rdata_q, sh, ext;
  assign is_st = ex_mem_op[3:2] == 2'b01;
  assign is_ld = ex_mem_op[3] && ex_mem_op != 4'b1111;
  assign acc = is_st || is_ld;
  assign sz = ex_mem_op[1:0];
  assign lane = ex_rd_data[2:0] & ~((3'd1 << sz) - 3'd1);
`ifdef MEM_MISALIGN_CHK_EN
  assign mis = acc && lane != ex_rd_data[2:0];
`else
  assign mis = 1'b0;
`endif
  assign strb = sz == 2'd0 ? 8'h01 << lane : sz == 2'd1 ? 8'h03 << lane : sz == 2'd2 ? 8'h0F << lane : 8'hFF;
  assign wdata = sz == 2'd0 ? {8{ex_mem_wdata[7:0]}} : sz == 2'd1 ? {4{ex_mem_wdata[15:0]}} :
                 sz == 2'd2 ? {2{ex_mem_wdata[31:0]}} : ex_mem_wdata;
  assign sh = rdata_q >> {lane_q, 3'b000};
  assign ext = sz_q == 2'd0 ? {{56{~uns_q & sh[7]}}, sh[7:0]} : sz_q == 2'd1 ? {{48{~uns_q & sh[15]}}, sh[15:0]} :
               sz_q == 2'd2 ? {{32{~uns_q & sh[31]}}, sh[31:0]} : sh;
  assign ok = ld_q && !mis_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mis_q <= 1'b0;
      we_q <= 1'b0;
      ld_q <= 1'b0;
      uns_q <= 1'b0;
      rd_ena_q <= 1'b0;
      sz_q <= 2'd0;
      lane_q <= 3'd0;
      rd_addr_q <= 5'd0;
      strb_q <= 8'd0;
      addr_q <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
    end else begin
      state <= next;
      if (state == IDLE && acc) begin
        mis_q <= mis;
        we_q <= is_st;
        ld_q <= is_ld;
        uns_q <= ex_mem_op[2];
        rd_ena_q <= ex_rd_ena;
        sz_q <= sz;
        lane_q <= lane;
        rd_addr_q <= ex_rd_addr;
        strb_q <= strb;
        addr_q <= {ex_rd_data[63:3], 3'b000};
        wdata_q <= wdata;
      end
      if (dmem_ack && ((state == IDLE && acc && !mis) || state == WAIT)) rdata_q <= dmem_rdata;
    end
  end
  always_comb begin
    next = state;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    dmem_addr = 64'd0;
    dmem_wdata = 64'd0;
    dmem_wstrb = 8'd0;
    mem_rd_data = 64'd0;
    mem_rd_addr = 5'd0;
    mem_rd_ena = 1'b0;
    stall_req_mem = 1'b0;
    mem_misalign = 1'b0;
    case (state)
      IDLE: begin
        stall_req_mem = acc;
        dmem_req = acc && !mis;
        if (dmem_req) begin
          dmem_we = is_st;
          dmem_addr = {ex_rd_data[63:3], 3'b000};
          dmem_wdata = wdata;
          dmem_wstrb = strb;
        end
        if (!acc) begin
          mem_rd_data = ex_rd_data;
          mem_rd_addr = ex_rd_addr;
          mem_rd_ena = ex_rd_ena;
        end
        next = !acc ? IDLE : (mis || dmem_ack) ? DONE : WAIT;
      end
      WAIT: begin
        stall_req_mem = 1'b1;
        dmem_req = 1'b1;
        dmem_we = we_q;
        dmem_addr = addr_q;
        dmem_wdata = wdata_q;
        dmem_wstrb = strb_q;
        next = dmem_ack ? DONE : WAIT;
      end
      DONE: begin
        mem_rd_data = ok ? ext : 64'd0;
        mem_rd_addr = rd_addr_q;
        mem_rd_ena = rd_ena_q && ok;
        mem_misalign = mis_q;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized self-checking bench for mem_lsu against a byte-level access model
module tb_mem_lsu;
  logic clk = 1'b0, rst = 1'b0;
  logic [63:0] ex_rd_data = '0, ex_mem_wdata = '0, dmem_rdata = '0;
  logic [4:0] ex_rd_addr = '0;
  logic ex_rd_ena = 1'b0, dmem_ack = 1'b0;
  logic [3:0] ex_mem_op = '0;
  logic dmem_req, dmem_we, mem_rd_ena, stall_req_mem, mem_misalign;
  logic [63:0] dmem_addr, dmem_wdata, mem_rd_data;
  logic [7:0] dmem_wstrb;
  logic [4:0] mem_rd_addr;
  int errors = 0, checks = 0;
  bit chk = 1'b0;
  mem_lsu dut (
    .clk(clk), .rst(rst), .ex_rd_data(ex_rd_data), .ex_rd_addr(ex_rd_addr), .ex_rd_ena(ex_rd_ena),
    .ex_mem_op(ex_mem_op), .ex_mem_wdata(ex_mem_wdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr), .mem_rd_ena(mem_rd_ena),
    .stall_req_mem(stall_req_mem), .mem_misalign(mem_misalign)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [63:0] model_load(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] rd);
    int nb = 1 << op[1:0];
    int a = int'(addr[2:0]);
    int ln = a - a % nb;
    logic [63:0] v = rd >> (8 * ln);
    logic [63:0] m;
    if (nb < 8) begin
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (!op[2] && v[8 * nb - 1]) v = v | ~m;
    end
    return v;
  endfunction
  task automatic drive_idle();
    ex_mem_op = 4'd0;
    ex_rd_data = '0;
    ex_rd_addr = '0;
    ex_rd_ena = 1'b0;
    ex_mem_wdata = '0;
    dmem_ack = 1'b0;
  endtask
  task automatic check_zero(input string tag);
    checks++;
    if (dmem_req !== 1'b0 || stall_req_mem !== 1'b0 || mem_rd_ena !== 1'b0 || mem_rd_data !== 64'd0 ||
        mem_rd_addr !== 5'd0 || mem_misalign !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 64'd0 ||
        dmem_wstrb !== 8'd0 || dmem_wdata !== 64'd0) begin
      errors++;
      $display("FAIL %s: req=%b stall=%b ena=%b data=%h addr=%h mis=%b we=%b daddr=%h strb=%h wdata=%h, all required 0",
               tag, dmem_req, stall_req_mem, mem_rd_ena, mem_rd_data, mem_rd_addr, mem_misalign, dmem_we,
               dmem_addr, dmem_wstrb, dmem_wdata);
    end
  endtask
  task automatic do_alu(input logic [3:0] op, input logic [63:0] d, input logic [4:0] rd, input logic ena);
    @(negedge clk);
    ex_mem_op = op;
    ex_rd_data = d;
    ex_rd_addr = rd;
    ex_rd_ena = ena;
    ex_mem_wdata = {$urandom, $urandom};
    #1;
    checks++;
    if (mem_rd_data !== d || mem_rd_addr !== rd || mem_rd_ena !== ena || stall_req_mem !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL alu op=%h: got data=%h rd=%0d ena=%b stall=%b req=%b, exp data=%h rd=%0d ena=%b stall=0 req=0",
               op, mem_rd_data, mem_rd_addr, mem_rd_ena, stall_req_mem, dmem_req, d, rd, ena);
    end
  endtask
  task automatic do_op(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rdat,
                       input logic [4:0] rd, input logic ena, input int k);
    int nb = 1 << op[1:0];
    int a = int'(addr[2:0]);
    int ln = a - a % nb;
    bit st = op[3:2] == 2'b01;
    bit mis = chk && (a % nb != 0);
    logic [7:0] exp_sb = 8'((((1 << nb) - 1) << ln) & 255);
    logic [63:0] exp_wd;
    logic [63:0] exp_rd;
    for (int i = 0; i < 8; i++) exp_wd[8 * i +: 8] = wd[8 * (i % nb) +: 8];
    exp_rd = (!st && !mis) ? model_load(op, addr, rdat) : 64'd0;
    for (int c = 0; c <= (mis ? 0 : k); c++) begin
      @(negedge clk);
      if (c == 0) begin
        ex_mem_op = op;
        ex_rd_data = addr;
        ex_mem_wdata = wd;
        ex_rd_addr = rd;
        ex_rd_ena = ena;
      end
      dmem_ack = !mis && c == k;
      dmem_rdata = dmem_ack ? rdat : {$urandom, $urandom};
      #1;
      checks++;
      if (stall_req_mem !== 1'b1 || dmem_req !== !mis || mem_rd_ena !== 1'b0 || mem_rd_data !== 64'd0 || mem_rd_addr !== 5'd0) begin
        errors++;
        $display("FAIL busy op=%h cyc=%0d: stall=%b req=%b ena=%b data=%h rd=%0d, exp stall=1 req=%b ena=0 data=0 rd=0",
                 op, c, stall_req_mem, dmem_req, mem_rd_ena, mem_rd_data, mem_rd_addr, !mis);
      end
      if (!mis) begin
        checks++;
        if (dmem_we !== st || dmem_addr !== {addr[63:3], 3'b000} || (st && (dmem_wstrb !== exp_sb || dmem_wdata !== exp_wd))) begin
          errors++;
          $display("FAIL bus op=%h cyc=%0d: we=%b addr=%h strb=%h wdata=%h, exp we=%b addr=%h strb=%h wdata=%h",
                   op, c, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, st, {addr[63:3], 3'b000}, exp_sb, exp_wd);
        end
      end
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    dmem_rdata = {$urandom, $urandom};
    #1;
    checks++;
    if (stall_req_mem !== 1'b0 || dmem_req !== 1'b0 || mem_misalign !== mis || mem_rd_ena !== (!st && !mis && ena) ||
        (!st && !mis && (mem_rd_data !== exp_rd || mem_rd_addr !== rd))) begin
      errors++;
      $display("FAIL done op=%h addr=%h: stall=%b req=%b mis=%b ena=%b data=%h rd=%0d, exp stall=0 req=0 mis=%b ena=%b data=%h rd=%0d",
               op, addr, stall_req_mem, dmem_req, mem_misalign, mem_rd_ena, mem_rd_data, mem_rd_addr,
               mis, !st && !mis && ena, exp_rd, rd);
    end
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
  endtask
  task automatic test_alu();
    do_alu(4'b0000, 64'h1234, 5'd5, 1'b1);
    do_alu(4'b1111, {$urandom, $urandom}, 5'd31, 1'b1);
    do_alu(4'b0011, {$urandom, $urandom}, 5'd7, 1'b0);
  endtask
  task automatic test_load();
    do_op(4'b1000, 64'h1003, 64'd0, 64'h00000000_80000000, 5'd10, 1'b1, 2);
    do_op(4'b1110, 64'h1004, 64'd0, 64'hDEADBEEF_00000000, 5'd11, 1'b1, 0);
    do_op(4'b1011, 64'h2000, 64'd0, 64'h8123456789ABCDEF, 5'd12, 1'b1, 1);
    do_op(4'b1001, 64'h2006, 64'd0, 64'h8001000000000000, 5'd13, 1'b1, 3);
    do_op(4'b1101, 64'h2006, 64'd0, 64'h8001000000000000, 5'd14, 1'b1, 0);
    do_op(4'b1010, 64'h2004, 64'd0, 64'h80000000_00000000, 5'd15, 1'b0, 1);
  endtask
  task automatic test_store();
    do_op(4'b0101, 64'h2006, 64'hABCD, 64'd0, 5'd3, 1'b1, 1);
    do_op(4'b0100, 64'h2005, 64'h5A, 64'd0, 5'd4, 1'b1, 0);
    do_op(4'b0110, 64'h2004, 64'h11223344, 64'd0, 5'd6, 1'b1, 2);
    do_op(4'b0111, 64'h2008, 64'h0102030405060708, 64'd0, 5'd8, 1'b1, 0);
  endtask
  task automatic test_reset_wait();
    @(negedge clk);
    ex_mem_op = 4'b1011;
    ex_rd_data = 64'h40;
    ex_rd_addr = 5'd9;
    ex_rd_ena = 1'b1;
    dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || stall_req_mem !== 1'b1) begin
      errors++;
      $display("FAIL wait_before_reset: req=%b stall=%b, exp 1 1", dmem_req, stall_req_mem);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    check_zero("after_reset_in_wait");
    dmem_ack = 1'b1;
    dmem_rdata = {$urandom, $urandom};
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check_zero("late_ack_ignored");
    do_op(4'b1100, 64'h47, 64'd0, 64'hF000000000000000, 5'd2, 1'b1, 1);
  endtask
  task automatic test_misalign();
`ifdef MEM_MISALIGN_CHK_EN
    chk = 1'b1;
    do_op(4'b1010, 64'h3002, 64'd0, 64'hFFFFFFFFFFFFFFFF, 5'd1, 1'b1, 0);
    do_op(4'b0111, 64'h3001, 64'h77, 64'd0, 5'd1, 1'b1, 0);
`endif
    do_op(4'b1010, 64'h3004, 64'd0, 64'h12345678_00000000, 5'd1, 1'b1, 1);
  endtask
  task automatic test_back_to_back();
    logic [3:0] codes [14] = '{4'h0, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF, 4'h3};
    logic [3:0] op;
    for (int n = 0; n < 60; n++) begin
      op = codes[$urandom_range(13)];
      if (op == 4'h0 || op == 4'hF || op == 4'h3)
        do_alu(op, {$urandom, $urandom}, 5'($urandom), 1'($urandom));
      else
        do_op(op, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 1'($urandom),
              int'($urandom_range(3)));
    end
  endtask
  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_reset_wait();
    test_misalign();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
